// File: rtl/sd_pkg.sv
// Shared types and sizing helpers for the SD card register bank.
// Holds the register-select encoding, the register widths and the load FSM states.
package sd_pkg;

    typedef enum logic [2:0] {
        SEL_CID = 3'd0,
        SEL_CSD = 3'd1,
        SEL_SCR = 3'd2,
        SEL_OCR = 3'd3,
        SEL_RCA = 3'd4,
        SEL_DSR = 3'd5
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int W_CID   = 128;
    localparam int W_CSD   = 128;
    localparam int W_SCR   = 64;
    localparam int W_OCR   = 32;
    localparam int W_RCA   = 16;
    localparam int W_DSR   = 16;
    localparam int STAGE_W = 128;
    localparam int CNT_W   = 8;

    function automatic int width_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return W_CID;
            3'd1:    return W_CSD;
            3'd2:    return W_SCR;
            3'd3:    return W_OCR;
            3'd4:    return W_RCA;
            default: return W_DSR;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] beats_for(input logic [2:0] sel, input int data_w);
        return CNT_W'(width_of(sel) / data_w);
    endfunction

endpackage

// File: rtl/register.sv
// Parametrised enable register with a synchronous active-high reset value.
module register #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sd_register_bank.sv
// SD card register bank: loads CID/CSD/SCR/OCR/RCA/DSR from an MSB-first response
// stream, accepts host writes to RCA/DSR and serves registered 32-bit word reads.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for load_start; stream not accepted
// ST_LOAD   | shifting beats into staging until the beat counter hits one
// ST_COMMIT | staging copied into the target register on the next edge
module sd_register_bank
    import sd_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter logic [15:0] RCA_RST = 16'h0000,
    parameter logic [15:0] DSR_RST = 16'h0404
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [2:0]        load_sel,
    input  logic              load_abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [5:0]        reg_valid,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [15:0]       wr_data,
    output logic              wr_err,
    input  logic [2:0]        rd_sel,
    input  logic [1:0]        rd_idx,
    output logic [31:0]       rd_data,
    output logic [127:0]      cid_out,
    output logic [127:0]      csd_out,
    output logic [63:0]       scr_out,
    output logic [31:0]       ocr_out,
    output logic [15:0]       rca_out,
    output logic [15:0]       dsr_out
);

    state_e             state_q;
    sel_e               sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [STAGE_W-1:0] stage_q;
    logic               load_done_q;
    logic               load_err_q;
    logic               wr_err_q;
    logic [5:0]         reg_valid_q;
    logic [31:0]        rd_data_q;

    logic               commit;
    sel_e               wr_tgt;
    logic [5:0]         commit_en;
    logic [15:0]        rca_d;
    logic [15:0]        dsr_d;
    logic [127:0]       rd_full_d;
    logic [31:0]        rd_word_d;

    assign commit = (state_q == ST_COMMIT);
    assign wr_tgt = wr_sel ? SEL_DSR : SEL_RCA;

    always_comb begin
        commit_en = '0;
        if (commit) begin
            commit_en[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_CID;
            cnt_q       <= '0;
            stage_q     <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            wr_err_q    <= 1'b0;
            reg_valid_q <= '0;
        end else begin
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            // A host write to the register being committed this cycle is dropped.
            wr_err_q    <= wr_en && commit && (sel_q == wr_tgt);
            if (commit) begin
                reg_valid_q[sel_q] <= 1'b1;
            end
            if (wr_en) begin
                reg_valid_q[wr_tgt] <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        if (load_sel > 3'd5) begin
                            load_err_q <= 1'b1;
                        end else begin
                            sel_q   <= sel_e'(load_sel);
                            stage_q <= '0;
                            cnt_q   <= beats_for(load_sel, DATA_W);
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    load_err_q <= load_start;
                    if (load_abort) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        stage_q <= {stage_q[STAGE_W-DATA_W-1:0], in_data};
                        cnt_q   <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    load_err_q  <= load_start;
                    load_done_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rca_d = commit_en[SEL_RCA] ? stage_q[15:0] : wr_data;
    assign dsr_d = commit_en[SEL_DSR] ? stage_q[15:0] : wr_data;

    register #(.WIDTH(W_CID), .RST_VAL('0)) u_cid (
        .clk(clk), .reset(reset), .en(commit_en[SEL_CID]),
        .d(stage_q[W_CID-1:0]), .q(cid_out));

    register #(.WIDTH(W_CSD), .RST_VAL('0)) u_csd (
        .clk(clk), .reset(reset), .en(commit_en[SEL_CSD]),
        .d(stage_q[W_CSD-1:0]), .q(csd_out));

    register #(.WIDTH(W_SCR), .RST_VAL('0)) u_scr (
        .clk(clk), .reset(reset), .en(commit_en[SEL_SCR]),
        .d(stage_q[W_SCR-1:0]), .q(scr_out));

    register #(.WIDTH(W_OCR), .RST_VAL('0)) u_ocr (
        .clk(clk), .reset(reset), .en(commit_en[SEL_OCR]),
        .d(stage_q[W_OCR-1:0]), .q(ocr_out));

    register #(.WIDTH(W_RCA), .RST_VAL(RCA_RST)) u_rca (
        .clk(clk), .reset(reset), .en(commit_en[SEL_RCA] | (wr_en & ~wr_sel)),
        .d(rca_d), .q(rca_out));

    register #(.WIDTH(W_DSR), .RST_VAL(DSR_RST)) u_dsr (
        .clk(clk), .reset(reset), .en(commit_en[SEL_DSR] | (wr_en & wr_sel)),
        .d(dsr_d), .q(dsr_out));

    always_comb begin
        rd_full_d = '0;
        case (rd_sel)
            3'd0:    rd_full_d = cid_out;
            3'd1:    rd_full_d = csd_out;
            3'd2:    rd_full_d = {64'b0, scr_out};
            3'd3:    rd_full_d = {96'b0, ocr_out};
            3'd4:    rd_full_d = {112'b0, rca_out};
            3'd5:    rd_full_d = {112'b0, dsr_out};
            default: rd_full_d = '0;
        endcase
        rd_word_d = rd_full_d[{rd_idx, 5'b0} +: 32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_word_d;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign load_busy = (state_q != ST_IDLE);
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign wr_err    = wr_err_q;
    assign reg_valid = reg_valid_q;
    assign rd_data   = rd_data_q;

endmodule
